// File: rtl/col_norm_pkg.sv
// col_norm_pkg
//   Shared definitions for the column carry normalizer.
//   SUM_W       : width of one column sum coming out of the compressor tree.
//   state_t     : frame sequencing states.
//   carry_width : carry register width for a given digit width.
package col_norm_pkg;

  localparam int SUM_W = 23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // The column sum plus the carry always stays below 2^24, so everything
  // above the digit is carry.
  function automatic int carry_width(input int digit_w);
    return 24 - digit_w;
  endfunction

endpackage

// File: rtl/col_carry_normalizer.sv
// col_carry_normalizer
//   Resolves carries across a stream of column sums, least-significant
//   column first. Each accepted column is added to the running carry. The
//   low DIGIT_W bits go out as a digit, and the remaining bits become the
//   carry for the next column. After the last column, one extra digit
//   carries the final carry.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | no frame open, carry=0, col_cnt=0
//   RUN   | frame open, accepting columns
//   FLUSH | last column taken, emitting the carry digit
//
// Ports
//   clk_sq    in   clock, rising edge
//   reset_sq  in   asynchronous active-low reset
//   in_sum    in   23-bit column sum
//   in_valid  in   in_sum / in_last valid
//   in_last   in   final column of a frame
//   in_ready  out  a column can be accepted this cycle
//   out_digit out  normalized DIGIT_W-bit digit
//   out_valid out  out_digit / out_last valid
//   out_last  out  marks the carry digit of a frame
//   out_ready in   downstream takes out_digit
//   err_len   out  sticky frame-length mismatch flag
//   busy      out  frame in progress
module col_carry_normalizer
  import col_norm_pkg::*;
#(
  parameter int DIGIT_W  = 16,
  parameter int NUM_COLS = 34
) (
  input  logic               clk_sq,
  input  logic               reset_sq,
  input  logic [SUM_W-1:0]   in_sum,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [DIGIT_W-1:0] out_digit,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready,
  output logic               err_len,
  output logic               busy
);

  localparam int CW    = carry_width(DIGIT_W);
  localparam int CNT_W = $clog2(NUM_COLS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_COLS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_COLS);

  state_t           state;
  logic [CW-1:0]    carry;
  logic [CNT_W-1:0] col_cnt;
  logic [23:0]      acc;
  logic             slot_free;
  logic             accept;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state != FLUSH) && slot_free;
  assign accept    = in_valid && in_ready;
  assign busy      = (state != IDLE);
  assign acc       = 24'(in_sum) + 24'(carry);

  always_ff @(posedge clk_sq or negedge reset_sq) begin
    if (!reset_sq) begin
      state     <= IDLE;
      carry     <= '0;
      col_cnt   <= '0;
      out_digit <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      if (accept) begin
        out_digit <= acc[DIGIT_W-1:0];
        out_valid <= 1'b1;
        out_last  <= 1'b0;
        carry     <= acc[23:DIGIT_W];
        // Saturate so an overlong frame cannot wrap back onto LAST_IDX.
        if (col_cnt != CNT_MAX)
          col_cnt <= col_cnt + CNT_W'(1);
        if (in_last) begin
          state <= FLUSH;
          if (col_cnt != LAST_IDX)
            err_len <= 1'b1;
        end else begin
          state <= RUN;
          if (col_cnt == LAST_IDX)
            err_len <= 1'b1;
        end
      end else if (state == FLUSH && slot_free) begin
        out_digit <= DIGIT_W'(carry);
        out_valid <= 1'b1;
        out_last  <= 1'b1;
        carry     <= '0;
        col_cnt   <= '0;
        state     <= IDLE;
      end
    end
  end

endmodule
